// File: rtl/fifo_sync_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_sync_param_if                                        |
// | Purpose  : Bundles the write/read handshake, data and status signals |
// |            of fifo_sync_param.                                       |
// | Signals  : data/wr_en/rd_en (master -> FIFO)                         |
// |            q, empty, full, almost_empty, almost_full, count,         |
// |            overflow, underflow (FIFO -> master)                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output data, wr_en, rd_en,
    input  q, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  data, wr_en, rd_en,
    output q, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_sync_param                                           |
// | Purpose  : Single-clock FIFO with occupancy count, almost-full/empty |
// |            thresholds, overflow/underflow pulses and optional        |
// |            first-word-fall-through read mode.                        |
// | Ports    : clk    - rising-edge clock                                |
// |            rst_n  - asynchronous active-low reset                    |
// |            bus    - fifo_sync_param_if.slave (data/wr_en/rd_en in;   |
// |                     q/flags/count/overflow/underflow out)            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input wire logic          clk,
  input wire logic          rst_n,
  fifo_sync_param_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth  = CW'(DEPTH);
  localparam logic [CW-1:0] c_afull  = CW'(AFULL_TH);
  localparam logic [CW-1:0] c_aempty = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode straight from the registered count, so they settle one
  // edge after the operation that changed it.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // A full FIFO rejects writes even alongside an accepted read, and an
  // empty FIFO rejects reads even alongside an accepted write.
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc && rst_n) begin
      r_mem[r_wr_ptr] <= bus.data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow of AW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= bus.wr_en & w_full;
      r_underflow <= bus.rd_en & w_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero while
      // empty so the output is clean after reset.
      assign bus.q = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_rd_acc) begin
          r_q <= r_mem[r_rd_ptr];
        end
      end
      assign bus.q = r_q;
    end
  endgenerate

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_count <= c_aempty);
  assign bus.almost_full  = (r_count >= c_afull);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fifo_sync_param                                        |
// | Purpose  : Self-checking bench for fifo_sync_param; one standard and |
// |            one FWFT instance share stimulus and a queue-based model. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fifo_sync_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WIDTH-1:0] tb_data = '0;
  logic tb_wr = 1'b0;
  logic tb_rd = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus0.data  = tb_data;
  assign bus0.wr_en = tb_wr;
  assign bus0.rd_en = tb_rd;
  assign bus1.data  = tb_data;
  assign bus1.wr_en = tb_wr;
  assign bus1.rd_en = tb_rd;

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  // Reference model: queue of stored words plus the expected standard-mode Q.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_qstd = '0;
  logic             m_ovf  = 1'b0;
  logic             m_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_qstd = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    int n;
    n = m_q.size();
    m_ovf = wr && (n == DEPTH);
    m_unf = rd && (n == 0);
    if (rd && n > 0) m_qstd = m_q.pop_front();
    if (wr && n < DEPTH) m_q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".count"},  32'(bus0.count),        32'(n));
    chk({tag, ".empty"},  32'(bus0.empty),        32'(n == 0));
    chk({tag, ".full"},   32'(bus0.full),         32'(n == DEPTH));
    chk({tag, ".aempty"}, 32'(bus0.almost_empty), 32'(n <= AE_TH));
    chk({tag, ".afull"},  32'(bus0.almost_full),  32'(n >= AF_TH));
    chk({tag, ".ovf"},    32'(bus0.overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(bus0.underflow),    32'(m_unf));
    chk({tag, ".q_std"},  32'(bus0.q),            32'(m_qstd));
    chk({tag, ".f_count"}, 32'(bus1.count),       32'(n));
    chk({tag, ".f_empty"}, 32'(bus1.empty),       32'(n == 0));
    if (n > 0) chk({tag, ".q_fwft"}, 32'(bus1.q), 32'(m_q[0]));
  endtask

  task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d, input string tag);
    @(negedge clk);
    tb_wr = wr;
    tb_rd = rd;
    tb_data = d;
    @(posedge clk);
    model_edge(wr, rd, d);
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed 3 ns after an edge and held 35 ns, so both edges of
  // the pulse fall between clock edges.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    tb_wr = 1'b0;
    tb_rd = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    chk({tag, ".q_fwft0"}, 32'(bus1.q), 32'h0);
    #34;
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across edges with a write requested: nothing accepted.
    rst_n   = 1'b0;
    tb_wr   = 1'b1;
    tb_data = 8'h77;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.q_fwft0", 32'(bus1.q), 32'h0);
    @(negedge clk);
    tb_wr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("release");

    // Fill 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), "fill");
    // Overflow attempt, then one idle cycle for the pulse to clear.
    step(1'b1, 1'b0, 8'h10, "ovf");
    step(1'b0, 1'b0, 8'h00, "ovf_idle");
    // Full with simultaneous read: write rejected, read accepted.
    step(1'b1, 1'b1, 8'h55, "full_rw");
    step(1'b1, 1'b0, 8'h00, "refill");
    // Drain all words, then underflow.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");
    step(1'b0, 1'b1, 8'h00, "unf");
    step(1'b1, 1'b1, 8'h66, "empty_rw");
    step(1'b0, 1'b1, 8'h00, "drain1");

    // Move pointers near the top, hold Count=5 across a wrap.
    reset_pulse("rst1");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), "pre");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(8'h30 + i), "adv");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h40 + i), "wrap");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "wdrain");

    // Random traffic in phases biased toward full, empty, and balanced.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 30), 8'($urandom), "rnd_up");
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 75), 8'($urandom), "rnd_dn");
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rnd_mix");

    // Reset mid-operation with Count=9.
    reset_pulse("rst2");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h90 + i), "nine");
    reset_pulse("rst3");
    step(1'b1, 1'b0, 8'hA5, "post_wr");
    step(1'b0, 1'b1, 8'h00, "post_rd");

    // FWFT fall-through into an empty FIFO.
    step(1'b1, 1'b0, 8'h3C, "fwft_wr");
    step(1'b0, 1'b0, 8'h00, "fwft_hold");
    step(1'b0, 1'b1, 8'h00, "fwft_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
